vscale_dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between the vscale core data interface and a host (HTIF/loader) requester.

---
 rtl/vscale_dmem_arb_pkg.sv | 6 +
 rtl/vscale_rr_arb2.sv | 10 +
 rtl/vscale_dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_vscale_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_dmem_arb_pkg.sv
// vscale_dmem_arb_pkg: shared FSM/owner types and the default mailbox address for the dmem arbiter.
package vscale_dmem_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
    typedef enum logic {OWN_CORE, OWN_HOST} owner_t;
    localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_1000;
endpackage

// File: rtl/vscale_rr_arb2.sv
// vscale_rr_arb2: two-way round-robin grant; on a tie the requester that did not own last wins.
module vscale_rr_arb2
    import vscale_dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] grant
);
    always_comb grant = &req ? (last == OWN_HOST ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/vscale_dmem_arbiter.sv
// vscale_dmem_arbiter: shares the data-memory port between core and host, one transaction in flight.
// Define VSCALE_DMEM_ARB_TOHOST_EN to capture core writes to TOHOST_ADDR in a local mailbox.
module vscale_dmem_arbiter
    import vscale_dmem_arb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(DEF_TOHOST_ADDR)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                core_req_valid,
    output logic                core_req_ready,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic                core_write,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_wmask,
    output logic                core_resp_valid,
    output logic [DATA_W-1:0]   core_rdata,
    input  logic                host_req_valid,
    output logic                host_req_ready,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic                host_write,
    input  logic [DATA_W-1:0]   host_wdata,
    input  logic [DATA_W/8-1:0] host_wmask,
    output logic                host_resp_valid,
    output logic [DATA_W-1:0]   host_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                tohost_valid,
    output logic [DATA_W-1:0]   tohost_data,
    input  logic                tohost_ack
);
    state_t     state;
    owner_t     owner, owner_last;
    logic [1:0] grant;
    logic       core_mbox, core_elig;

`ifdef VSCALE_DMEM_ARB_TOHOST_EN
    assign core_mbox = core_write && core_addr == TOHOST_ADDR;
    // a full mailbox stalls only mailbox writes; the host keeps being served
    assign core_elig = core_req_valid && !(core_mbox && tohost_valid);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tohost_valid <= 1'b0;
            tohost_data  <= '0;
        end else if (core_req_ready && core_mbox) begin
            tohost_valid <= 1'b1;
            tohost_data  <= core_wdata;
        end else if (tohost_ack) begin
            tohost_valid <= 1'b0;
        end
    end
`else
    logic unused_cfg;
    assign core_mbox    = 1'b0;
    assign core_elig    = core_req_valid;
    assign tohost_valid = 1'b0;
    assign tohost_data  = '0;
    assign unused_cfg   = ^{tohost_ack, TOHOST_ADDR};
`endif

    vscale_rr_arb2 u_arb (
        .req   ({host_req_valid, core_elig}),
        .last  (owner_last),
        .grant (grant)
    );

    assign core_req_ready = reset_n && state == ST_IDLE && grant[0];
    assign host_req_ready = reset_n && state == ST_IDLE && grant[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            owner           <= OWN_CORE;
            owner_last      <= OWN_HOST;
            mem_req_valid   <= 1'b0;
            mem_addr        <= '0;
            mem_write       <= 1'b0;
            mem_wdata       <= '0;
            mem_wmask       <= '0;
            core_resp_valid <= 1'b0;
            host_resp_valid <= 1'b0;
            core_rdata      <= '0;
            host_rdata      <= '0;
        end else begin
            core_resp_valid <= 1'b0;
            host_resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (core_req_ready && core_mbox) begin
                        core_resp_valid <= 1'b1;
                        owner_last      <= OWN_CORE;
                    end else if (|grant) begin
                        owner         <= grant[1] ? OWN_HOST : OWN_CORE;
                        mem_req_valid <= 1'b1;
                        mem_addr      <= grant[1] ? host_addr : core_addr;
                        mem_write     <= grant[1] ? host_write : core_write;
                        mem_wdata     <= grant[1] ? host_wdata : core_wdata;
                        mem_wmask     <= grant[1] ? host_wmask : core_wmask;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_resp_valid) begin
                        core_resp_valid <= owner == OWN_CORE;
                        host_resp_valid <= owner == OWN_HOST;
                        core_rdata      <= owner == OWN_CORE ? mem_rdata : core_rdata;
                        host_rdata      <= owner == OWN_HOST ? mem_rdata : host_rdata;
                        owner_last      <= owner;
                        state           <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vscale_dmem_arbiter.sv
// tb_vscale_dmem_arbiter: random and directed traffic checked against a transaction-level model.
module tb_vscale_dmem_arbiter;
`ifdef VSCALE_DMEM_ARB_TOHOST_EN
    localparam bit MBOX = 1'b1;
`else
    localparam bit MBOX = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        core_req_valid = 0, core_req_ready, core_write = 0, core_resp_valid;
    logic [31:0] core_addr = 0, core_wdata = 0, core_rdata;
    logic [3:0]  core_wmask = 0;
    logic        host_req_valid = 0, host_req_ready, host_write = 0, host_resp_valid;
    logic [31:0] host_addr = 0, host_wdata = 0, host_rdata;
    logic [3:0]  host_wmask = 0;
    logic        mem_req_valid, mem_req_ready = 0, mem_write, mem_resp_valid = 0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic [3:0]  mem_wmask;
    logic        tohost_valid, tohost_ack = 0;
    logic [31:0] tohost_data;

    always #5 clk = ~clk;

    vscale_dmem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_addr(core_addr),
        .core_write(core_write), .core_wdata(core_wdata), .core_wmask(core_wmask),
        .core_resp_valid(core_resp_valid), .core_rdata(core_rdata),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready), .host_addr(host_addr),
        .host_write(host_write), .host_wdata(host_wdata), .host_wmask(host_wmask),
        .host_resp_valid(host_resp_valid), .host_rdata(host_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .tohost_valid(tohost_valid), .tohost_data(tohost_data), .tohost_ack(tohost_ack)
    );

    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // requesters, memory and stimulus controls
    bit          c_pend, h_pend, m_rdy, ack_in, spur, m_busy, saw_1000;
    req_t        c_p, h_p;
    int          lat, m_cnt;
    logic [31:0] m_data;
    logic [31:0] mem [logic [31:0]];
    // transaction-level expectation: who owns the port, has it reached memory, who gets a reply
    int          own, last_own, rsp_to;
    bit          issued, rsp_chk, tv;
    req_t        cur;
    logic [31:0] rsp_data, td;
    int          grants [$];

    function automatic req_t rand_req(input bit core);
        req_t r;
        int   k = $urandom_range(0, 3);
        r.addr  = k == 0 ? 32'h200 : k == 1 ? 32'h204 : (k == 2 && core) ? 32'h1000 : ($urandom & 32'hFFFC);
        r.wr    = 1'($urandom_range(0, 1));
        r.wdata = $urandom;
        r.wmask = 4'($urandom);
        return r;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic model_reset();
        c_pend = 0; h_pend = 0; own = -1; last_own = 1; rsp_to = -1;
        issued = 0; rsp_chk = 0; tv = 0; td = 0;
        grants.delete();
    endtask

    // one clock: check registered outputs, drive inputs, check readies, advance model
    task automatic step();
        bit          mbox, ce, real_rsp;
        int          win;
        logic [31:0] old;
        check("mem_req_valid", 32'(mem_req_valid), 32'(own >= 0 && !issued));
        if (own >= 0 && !issued) begin
            check("mem_addr", mem_addr, cur.addr);
            check("mem_write", 32'(mem_write), 32'(cur.wr));
            check("mem_wdata", mem_wdata, cur.wdata);
            check("mem_wmask", 32'(mem_wmask), 32'(cur.wmask));
        end
        check("core_resp_valid", 32'(core_resp_valid), 32'(rsp_to == 0));
        check("host_resp_valid", 32'(host_resp_valid), 32'(rsp_to == 1));
        if (rsp_to == 0 && rsp_chk) check("core_rdata", core_rdata, rsp_data);
        if (rsp_to == 1) check("host_rdata", host_rdata, rsp_data);
        check("tohost_valid", 32'(tohost_valid), 32'(tv));
        check("tohost_data", tohost_data, td);
        core_req_valid = c_pend;
        {core_addr, core_write, core_wdata, core_wmask} = c_pend ? c_p : req_t'({$urandom, $urandom, $urandom});
        host_req_valid = h_pend;
        {host_addr, host_write, host_wdata, host_wmask} = h_pend ? h_p : req_t'({$urandom, $urandom, $urandom});
        mem_req_ready  = m_rdy;
        tohost_ack     = ack_in;
        real_rsp       = m_busy && m_cnt == 0;
        mem_resp_valid = real_rsp || (!m_busy && spur);
        mem_rdata      = m_busy ? m_data : $urandom;
        #1;
        mbox = MBOX && c_pend && c_p.wr && c_p.addr == 32'h1000;
        ce   = c_pend && !(mbox && tv);
        win  = own >= 0 ? -1 : (ce && h_pend) ? (last_own == 1 ? 0 : 1) : ce ? 0 : h_pend ? 1 : -1;
        check("core_req_ready", 32'(core_req_ready), 32'(win == 0));
        check("host_req_ready", 32'(host_req_ready), 32'(win == 1));
        if (real_rsp) m_busy = 0;
        else if (m_busy) m_cnt--;
        if (mem_req_valid && mem_req_ready) begin
            if (mem_addr == 32'h1000) saw_1000 = 1;
            old = mem_rd(mem_addr);
            if (mem_write) begin
                for (int b = 0; b < 4; b++) if (mem_wmask[b]) old[8*b +: 8] = mem_wdata[8*b +: 8];
                mem[mem_addr] = old;
                m_data = $urandom;
            end else m_data = old;
            m_busy = 1;
            m_cnt  = lat;
        end
        rsp_to = -1;
        if (real_rsp && own >= 0 && issued) begin
            rsp_to = own; rsp_chk = 1; rsp_data = mem_rdata; last_own = own; own = -1;
        end else if (own >= 0 && !issued && m_rdy) begin
            issued = 1;
        end else if (win == 0 && mbox) begin
            rsp_to = 0; rsp_chk = 0; last_own = 0; tv = 1; td = c_p.wdata; c_pend = 0;
            grants.push_back(0);
        end else if (win >= 0) begin
            own = win; cur = win == 1 ? h_p : c_p; issued = 0;
            if (win == 1) h_pend = 0; else c_pend = 0;
            grants.push_back(win);
        end
        if (!(win == 0 && mbox) && ack_in) tv = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 0; m_busy = 0; ack_in = 0; spur = 0;
        core_req_valid = 0; host_req_valid = 0; mem_resp_valid = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        model_reset();
    endtask

    initial begin
        m_rdy = 1; lat = 0; ack_in = 0; spur = 0; m_busy = 0; saw_1000 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req_valid", 32'(mem_req_valid), 0);
        check("rst_core_ready", 32'(core_req_ready), 0);
        check("rst_resp", 32'({core_resp_valid, host_resp_valid}), 0);
        check("rst_rdata", core_rdata | host_rdata, 0);
        check("rst_tohost", 32'(tohost_valid) | tohost_data, 0);
        reset_n = 1;

        // single core read with two idle cycles of memory latency
        mem[32'h200] = 32'hDEAD_BEEF;
        c_p = '{32'h200, 1'b0, 32'h0, 4'hF}; c_pend = 1; lat = 2;
        repeat (8) step();
        check("t1_rdata", core_rdata, 32'hDEAD_BEEF);

        // both requesters saturate: alternating grants starting with core
        do_reset();
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            if (!c_pend) begin c_p = rand_req(0); c_pend = 1; end
            if (!h_pend) begin h_p = rand_req(0); h_pend = 1; end
            step();
        end
        check("t2_ngrants", 32'(grants.size() >= 4), 1);
        for (int i = 0; i < 4 && i < grants.size(); i++) check("t2_grant", grants[i], i % 2);
        repeat (6) step();

        // memory back-pressure holds the request stable
        c_p = '{32'h204, 1'b1, 32'hCAFE_F00D, 4'h3}; c_pend = 1; m_rdy = 0;
        repeat (6) step();
        m_rdy = 1;
        repeat (6) step();
        check("t3_stored", mem_rd(32'h204) & 32'hFFFF, 32'hF00D);

        // write to the mailbox address
        do_reset();
        saw_1000 = 0;
        c_p = '{32'h1000, 1'b1, 32'h1, 4'hF}; c_pend = 1;
        repeat (4) step();
        if (MBOX) begin
            check("t4_tohost_valid", 32'(tohost_valid), 1);
            check("t4_tohost_data", tohost_data, 1);
            check("t4_no_mem", 32'(saw_1000), 0);
            c_p = '{32'h1000, 1'b1, 32'h7, 4'hF}; c_pend = 1;
            repeat (4) step();
            check("t4_stalled", tohost_data, 1);
            ack_in = 1;
            step();
            ack_in = 0;
            repeat (3) step();
            check("t4_tohost_data2", tohost_data, 7);
            check("t4_tohost_valid2", 32'(tohost_valid), 1);
        end else begin
            check("t5_mem_1000", 32'(saw_1000), 1);
            check("t5_tohost_valid", 32'(tohost_valid), 0);
        end

        // reset asserted while waiting for the memory response
        do_reset();
        c_p = '{32'h200, 1'b0, 32'h0, 4'hF}; c_pend = 1; lat = 5;
        repeat (3) step();
        core_req_valid = 1;
        reset_n = 0;
        #1;
        check("t6_mem_req_valid", 32'(mem_req_valid), 0);
        check("t6_core_ready", 32'(core_req_ready), 0);
        check("t6_resp", 32'({core_resp_valid, host_resp_valid}), 0);
        check("t6_rdata", core_rdata, 0);
        core_req_valid = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        model_reset();
        repeat (8) step();

        // randomized mixed traffic with spurious responses and back-pressure
        for (int i = 0; i < 1500; i++) begin
            if (!c_pend && $urandom_range(0, 2) == 0) begin c_p = rand_req(1); c_pend = 1; end
            if (!h_pend && $urandom_range(0, 2) == 0) begin h_p = rand_req(0); h_pend = 1; end
            m_rdy  = $urandom_range(0, 3) != 0;
            lat    = $urandom_range(0, 2);
            spur   = $urandom_range(0, 5) == 0;
            ack_in = $urandom_range(0, 3) == 0;
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
